// File: rtl/clock_time_setter_pkg.sv
// Shared types, field widths, wrap limits and helpers for the set-time control stage.
package clock_time_setter_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } state_e;

    localparam int unsigned HrTensW  = 2;
    localparam int unsigned HrOnesW  = 4;
    localparam int unsigned MinTensW = 3;
    localparam int unsigned MinOnesW = 4;

    localparam int unsigned HrMax      = 23;
    localparam int unsigned MinTensMax = 5;
    localparam int unsigned OnesMax    = 9;

    typedef struct packed {
        logic [HrTensW-1:0] tens;
        logic [HrOnesW-1:0] ones;
    } hr_bcd_t;

    typedef struct packed {
        logic [MinTensW-1:0] tens;
        logic [MinOnesW-1:0] ones;
    } min_bcd_t;

    function automatic int unsigned ms_to_cycles(int unsigned clk_hz, int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

    function automatic int unsigned blink_half_cycles(int unsigned clk_hz, int unsigned blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Any value at or past 23 (including captured junk) wraps to 00.
    function automatic hr_bcd_t bcd_inc_hr(hr_bcd_t v);
        hr_bcd_t     r;
        int unsigned value;
        value = {30'd0, v.tens} * 10 + {28'd0, v.ones};
        if (value >= HrMax || v.ones > HrOnesW'(OnesMax)) begin
            r = '0;
        end else if (v.ones == HrOnesW'(OnesMax)) begin
            r.tens = v.tens + 1'b1;
            r.ones = '0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 1'b1;
        end
        return r;
    endfunction

    function automatic min_bcd_t bcd_inc_min(min_bcd_t v);
        min_bcd_t r;
        if (v.tens > MinTensW'(MinTensMax) ||
            (v.tens == MinTensW'(MinTensMax) && v.ones >= MinOnesW'(OnesMax))) begin
            r = '0;
        end else if (v.ones >= MinOnesW'(OnesMax)) begin
            r.tens = v.tens + 1'b1;
            r.ones = '0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_time_setter_button_debouncer.sv
// Two-flop synchroniser, stable-level filter and one-cycle rising-edge pulse for one button.
module button_debouncer #(
    parameter int unsigned DbCyc = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = (DbCyc > 1) ? $clog2(DbCyc) : 1;

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d, stable_dly_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Level only moves after DbCyc consecutive cycles disagreeing with it.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DbCyc - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/clock_time_setter.sv
// Set-time control: debounced MODE/INC, auto-repeat, RUN/SET_HR/SET_MIN FSM, BCD presets, blink.
module clock_time_setter
    import clock_time_setter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned REPEAT_MS   = 300,
    parameter int unsigned BLINK_HZ    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_mode,
    input  logic                btn_inc,
    input  logic [HrTensW-1:0]  cur_hr_tens,
    input  logic [HrOnesW-1:0]  cur_hr_ones,
    input  logic [MinTensW-1:0] cur_min_tens,
    input  logic [MinOnesW-1:0] cur_min_ones,
    output logic [HrTensW-1:0]  set_hr_tens,
    output logic [HrOnesW-1:0]  set_hr_ones,
    output logic [MinTensW-1:0] set_min_tens,
    output logic [MinOnesW-1:0] set_min_ones,
    output logic                load,
    output logic                setting,
    output logic                blink_hr,
    output logic                blink_min
);

    localparam int unsigned DbCyc     = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned RepCyc    = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam int unsigned BlinkHalf = blink_half_cycles(CLK_HZ, BLINK_HZ);
    localparam int unsigned RepW      = cnt_width(RepCyc);
    localparam int unsigned BlinkW    = cnt_width(BlinkHalf);

    logic mode_press, inc_press, inc_level, unused_mode_level;

    button_debouncer #(.DbCyc(DbCyc)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .level (unused_mode_level),
        .press (mode_press)
    );

    button_debouncer #(.DbCyc(DbCyc)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    logic [RepW-1:0] rep_q, rep_d;
    logic            rep_fire, inc_evt;

    always_comb begin
        rep_fire = inc_level && (rep_q == RepW'(RepCyc - 1));
        rep_d    = rep_q + RepW'(1);
        if (!inc_level || rep_fire) begin
            rep_d = '0;
        end
    end

    // MODE has priority; a coincident INC is dropped.
    assign inc_evt = (inc_press | rep_fire) & ~mode_press;

    state_e   state_q, state_d;
    hr_bcd_t  hr_q, hr_d;
    min_bcd_t min_q, min_d;
    logic     load_q, load_d, setting_q, setting_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            unique case (state_q)
                StRun:    state_d = StSetHr;
                StSetHr:  state_d = StSetMin;
                StSetMin: state_d = StRun;
                default:  state_d = StRun;
            endcase
        end
    end

    always_comb begin
        hr_d      = hr_q;
        min_d     = min_q;
        load_d    = 1'b0;
        setting_d = (state_d != StRun);
        if (mode_press) begin
            if (state_q == StRun) begin
                hr_d  = {cur_hr_tens, cur_hr_ones};
                min_d = {cur_min_tens, cur_min_ones};
            end else if (state_q == StSetMin) begin
                load_d = 1'b1;
            end
        end else if (inc_evt) begin
            if (state_q == StSetHr) begin
                hr_d = bcd_inc_hr(hr_q);
            end else if (state_q == StSetMin) begin
                min_d = bcd_inc_min(min_q);
            end
        end
    end

    logic [BlinkW-1:0] blink_cnt_q;
    logic              phase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q       <= '0;
            hr_q        <= '0;
            min_q       <= '0;
            load_q      <= 1'b0;
            setting_q   <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            rep_q     <= rep_d;
            hr_q      <= hr_d;
            min_q     <= min_d;
            load_q    <= load_d;
            setting_q <= setting_d;
            if (blink_cnt_q == BlinkW'(BlinkHalf - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BlinkW'(1);
            end
        end
    end

    assign set_hr_tens  = hr_q.tens;
    assign set_hr_ones  = hr_q.ones;
    assign set_min_tens = min_q.tens;
    assign set_min_ones = min_q.ones;
    assign load         = load_q;
    assign setting      = setting_q;
    assign blink_hr     = (state_q == StSetHr) & phase_q;
    assign blink_min    = (state_q == StSetMin) & phase_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Randomised bench: a time-level model queues expected output changes; a monitor compares them.
module tb_clock_time_setter;

    localparam int unsigned BlinkHalf = 1000 / (2 * 50);

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode = 1'b0, btn_inc = 1'b0;
    logic [1:0] cur_hr_tens = '0;
    logic [3:0] cur_hr_ones = '0;
    logic [2:0] cur_min_tens = '0;
    logic [3:0] cur_min_ones = '0;
    logic [1:0] set_hr_tens;
    logic [3:0] set_hr_ones;
    logic [2:0] set_min_tens;
    logic [3:0] set_min_ones;
    logic       load, setting, blink_hr, blink_min;

    always #5 clk = ~clk;

    clock_time_setter #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .REPEAT_MS   (20),
        .BLINK_HZ    (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .cur_hr_tens  (cur_hr_tens),
        .cur_hr_ones  (cur_hr_ones),
        .cur_min_tens (cur_min_tens),
        .cur_min_ones (cur_min_ones),
        .set_hr_tens  (set_hr_tens),
        .set_hr_ones  (set_hr_ones),
        .set_min_tens (set_min_tens),
        .set_min_ones (set_min_ones),
        .load         (load),
        .setting      (setting),
        .blink_hr     (blink_hr),
        .blink_min    (blink_min)
    );

    typedef struct {
        bit setting;
        bit load;
        int hh;
        int mm;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;

    // Model: 0 = running, 1 = editing hours, 2 = editing minutes.
    int model_st = 0, sh = 0, sm = 0, cur_h = 0, cur_m = 0;

    function automatic snap_t observe();
        snap_t s;
        s.setting = setting;
        s.load    = load;
        s.hh      = int'(set_hr_tens) * 10 + int'(set_hr_ones);
        s.mm      = int'(set_min_tens) * 10 + int'(set_min_ones);
        return s;
    endfunction

    function automatic bit same(snap_t a, snap_t b);
        return a.setting == b.setting && a.load == b.load && a.hh == b.hh && a.mm == b.mm;
    endfunction

    function automatic void push(bit s, bit l, int h, int m);
        snap_t e;
        e.setting = s;
        e.load    = l;
        e.hh      = h;
        e.mm      = m;
        exp_q.push_back(e);
    endfunction

    initial begin : monitor
        snap_t prev, now, e;
        prev = observe();
        forever begin
            @(negedge clk);
            now = observe();
            if (rst && !same(now, prev)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: got setting=%0d load=%0d set=%0d:%0d, required no change",
                             now.setting, now.load, now.hh, now.mm);
                end else begin
                    e = exp_q.pop_front();
                    if (!same(now, e)) begin
                        fails++;
                        $display("FAIL output_event: got setting=%0d load=%0d set=%0d:%0d, required setting=%0d load=%0d set=%0d:%0d",
                                 now.setting, now.load, now.hh, now.mm, e.setting, e.load, e.hh, e.mm);
                    end
                end
            end
            prev = now;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(bit m, bit i, int hold);
        @(posedge clk);
        #1;
        btn_mode = m;
        btn_inc  = i;
        cycles(hold);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cycles(12);
    endtask

    task automatic set_cur(int h, int m);
        cur_h        = h;
        cur_m        = m;
        cur_hr_tens  = 2'(h / 10);
        cur_hr_ones  = 4'(h % 10);
        cur_min_tens = 3'(m / 10);
        cur_min_ones = 4'(m % 10);
    endtask

    function automatic int next_hr(int h);
        return (h >= 23) ? 0 : h + 1;
    endfunction

    function automatic int next_min(int m);
        return (m >= 59) ? 0 : m + 1;
    endfunction

    function automatic void model_mode();
        if (model_st == 0) begin
            sh = cur_h;
            sm = cur_m;
            push(1, 0, sh, sm);
            model_st = 1;
        end else if (model_st == 1) begin
            model_st = 2;
        end else begin
            push(0, 1, sh, sm);
            push(0, 0, sh, sm);
            model_st = 0;
        end
    endfunction

    function automatic void model_inc();
        if (model_st == 1) begin
            sh = next_hr(sh);
            push(1, 0, sh, sm);
        end else if (model_st == 2) begin
            sm = next_min(sm);
            push(1, 0, sh, sm);
        end
    endfunction

    task automatic do_mode();
        model_mode();
        press(1, 0, 10);
    endtask

    task automatic do_inc();
        model_inc();
        press(0, 1, 10);
    endtask

    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        cycles(2);
        check_int(name, exp_q.size(), 0);
    endtask

    // Blink of the selected field toggles every BlinkHalf cycles; the other stays low.
    task automatic check_blink(bit hr_field, string name);
        int  last_t = -1, toggles = 0, other_hi = 0;
        logic prev_b, b;
        @(negedge clk);
        prev_b = hr_field ? blink_hr : blink_min;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            b = hr_field ? blink_hr : blink_min;
            if ((hr_field ? blink_min : blink_hr) !== 1'b0) other_hi++;
            if (b !== prev_b) begin
                if (last_t >= 0) check_int({name, "_period"}, t - last_t, BlinkHalf);
                last_t = t;
                toggles++;
            end
            prev_b = b;
        end
        check_int({name, "_toggles_min4"}, (toggles >= 4) ? 1 : 0, 1);
        check_int({name, "_other_low"}, other_hi, 0);
    endtask

    initial begin : stimulus
        int n, hi;
        rst = 1'b0;
        set_cur(14, 37);
        cycles(3);
        check_int("reset_setting", int'(setting), 0);
        check_int("reset_load", int'(load), 0);
        check_int("reset_set_time", observe().hh * 100 + observe().mm, 0);
        rst = 1'b1;
        cycles(3);

        // Bounce on MODE: only the final steady level counts.
        model_mode();
        for (int k = 0; k < 10; k++) begin
            btn_mode = (k % 4) < 2;
            cycles(1);
        end
        btn_mode = 1'b1;
        cycles(10);
        btn_mode = 1'b0;
        cycles(12);
        drain("bounce_drain");
        check_int("bounce_setting", int'(setting), 1);
        check_blink(1'b1, "blink_sethr");

        // Reset mid-edit clears everything at once.
        do_inc();
        drain("pre_reset_drain");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_int("midreset_setting", int'(setting), 0);
        check_int("midreset_set_time", observe().hh * 100 + observe().mm, 0);
        check_int("midreset_blink", int'(blink_hr) + int'(blink_min), 0);
        exp_q.delete();
        model_st = 0;
        sh = 0;
        sm = 0;
        cycles(3);
        rst = 1'b1;
        cycles(20);
        check_int("post_reset_load", int'(load), 0);
        check_int("post_reset_setting", int'(setting), 0);

        // RUN: INC ignored, no blinking.
        do_inc();
        hi = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (blink_hr || blink_min) hi++;
        end
        check_int("blink_run_low", hi, 0);

        // Hour wrap 22 -> 23 -> 00.
        set_cur(22, 59);
        do_mode();
        do_inc();
        do_inc();
        do_mode();
        check_blink(1'b0, "blink_setmin");
        do_mode();
        drain("hour_wrap_drain");

        // Minute carry plus auto-repeat: one press and three repeats.
        set_cur(10, 8);
        do_mode();
        do_mode();
        for (int k = 0; k < 4; k++) model_inc();
        press(0, 1, 70);
        do_mode();
        drain("repeat_drain");

        // Simultaneous MODE+INC in hours: MODE wins.
        set_cur(5, 30);
        do_mode();
        model_mode();
        press(1, 1, 10);
        do_inc();
        do_mode();
        drain("simultaneous_drain");

        // Out-of-range captured hour wraps to 00 on the first INC.
        set_cur(27, 45);
        do_mode();
        do_inc();
        do_mode();
        do_mode();
        drain("out_of_range_drain");

        for (int it = 0; it < 8; it++) begin
            set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            do_mode();
            n = int'($urandom_range(0, 4));
            for (int k = 0; k < n; k++) do_inc();
            do_mode();
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) do_inc();
            do_mode();
            drain("random_drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
